// File: rtl/dram_resp.sv
// Flat word-addressed DRAM model with a fixed-latency read pipeline and one write port.
// Optional DRAM_RESP_BYPASS_EN: same-edge read/write collisions return wr_data (write-first).
module dram_resp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_stage_data [RD_LATENCY];
    logic [RD_LATENCY-1:0] r_stage_vld;
    logic [DATA_WIDTH-1:0] w_rd_word;

    // Array contents survive reset; only requests presented during reset are dropped.
    always_ff @(posedge clk) begin
        if (wr_en && !srst) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

`ifdef DRAM_RESP_BYPASS_EN
    assign w_rd_word = (wr_en && (wr_addr == rd_addr)) ? wr_data : r_mem[rd_addr];
`else
    assign w_rd_word = r_mem[rd_addr];
`endif

    // Stage data only advances behind a valid bit, so the last stage holds its word when idle.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_stage_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_stage_data[i] <= '0;
            end
        end else begin
            r_stage_vld[0] <= rd_en;
            if (rd_en) begin
                r_stage_data[0] <= w_rd_word;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_stage_vld[i] <= r_stage_vld[i-1];
                if (r_stage_vld[i-1]) begin
                    r_stage_data[i] <= r_stage_data[i-1];
                end
            end
        end
    end

    assign rd_data  = r_stage_data[RD_LATENCY-1];
    assign rd_valid = r_stage_vld[RD_LATENCY-1];
    assign busy     = |r_stage_vld;

endmodule
